// File: rtl/leaf_scan_sched.sv
// -----------------------------------------------------------------------------
// leaf_scan_sched
//
// Walks the candidate-leaf list of one ANN search job and streams every
// point of every leaf into the 8-wide running-minimum stage. One leaf index
// is taken at a time. The point address then steps 0 .. LEAF_SIZE-1 with one
// leaf-memory read per cycle. Each read is tagged at issue time. The tag
// travels through a READ_LAT-deep pipe, so the min-stage strobes line up with
// the returning read data.
//
// Handshakes: a transfer on job_* or leaf_* takes place on a rising clk edge
// where valid and ready are both high. valid may be raised at any time.
// ready never depends on the valid of the same channel. The offered payload
// is only sampled on the transfer edge.
//
// Parameters
//   LEAF_SIZE        points per leaf (2..512)
//   READ_LAT         leaf-memory read latency in cycles (1..4)
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   job_valid/ready  job offer; job_ready is high only in IDLE
//   job_num_leaves   leaves in the offered job (0..15)
//   leaf_valid/ready candidate leaf offer; leaf_ready = FETCH & ~pause
//   leaf_idx         candidate leaf index
//   pause            downstream back-pressure, blocks reads and leaf accept
//   mem_csb          leaf-memory chip select, active-low
//   mem_leaf_addr    leaf being read
//   mem_pt_addr      point within the leaf
//   dp_valid         min stage valid_in
//   dp_restart       min stage restart (first point of the job)
//   dp_query_last    min stage query_last_in (last point of the job)
//   dp_leaf_idx      min stage leaf_idx_in
//   busy             state is not IDLE
//   job_done         one-cycle completion pulse (DONE state)
//   perf_busy_cycles, perf_pause_cycles
//                    saturating activity counters, present only when the
//                    LEAF_SCAN_PERF_EN macro is defined
//   dbg_state        current FSM state encoding (state_t)
// -----------------------------------------------------------------------------
module leaf_scan_sched #(
    parameter int LEAF_SIZE = 8,
    parameter int READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [3:0]  job_num_leaves,
    input  logic        leaf_valid,
    output logic        leaf_ready,
    input  logic [5:0]  leaf_idx,
    input  logic        pause,
    output logic        mem_csb,
    output logic [5:0]  mem_leaf_addr,
    output logic [8:0]  mem_pt_addr,
    output logic        dp_valid,
    output logic        dp_restart,
    output logic        dp_query_last,
    output logic [5:0]  dp_leaf_idx,
    output logic        busy,
    output logic        job_done,
`ifdef LEAF_SCAN_PERF_EN
    output logic [31:0] perf_busy_cycles,
    output logic [31:0] perf_pause_cycles,
`endif
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [8:0] PT_LAST = 9'(LEAF_SIZE - 1);

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  leaves_left;
    logic [5:0]  leaf_reg;
    logic [8:0]  pt_cnt;
    logic        first_leaf;

    logic        job_acc;
    logic        leaf_acc;
    logic        issue;
    logic        pt_at_end;
    logic        last_leaf;

    // Read-tag pipe, stage 0 is loaded on the issue edge.
    logic        pv    [READ_LAT];
    logic        pf    [READ_LAT];
    logic        pl    [READ_LAT];
    logic [5:0]  pleaf [READ_LAT];
    logic        pipe_inner_valid;

    // -------------------------------------------------------------------------
    // Handshake and issue qualifiers
    // -------------------------------------------------------------------------
    always_comb begin
        job_ready  = (state == S_IDLE);
        leaf_ready = (state == S_FETCH) && !pause;
        job_acc    = job_valid && job_ready;
        leaf_acc   = leaf_valid && leaf_ready;
        issue      = (state == S_SCAN) && !pause;
        pt_at_end  = (pt_cnt == PT_LAST);
        last_leaf  = (leaves_left == 4'd1);
    end

    // The final stage is draining this cycle. DRAIN only waits for the stages
    // in front of it. The job then completes on the cycle after the last tag
    // leaves the pipe.
    always_comb begin
        pipe_inner_valid = 1'b0;
        for (int i = 0; i < READ_LAT - 1; i++) begin
            pipe_inner_valid = pipe_inner_valid | pv[i];
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (job_valid) begin
                    state_nxt = (job_num_leaves == 4'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (leaf_acc) begin
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (issue && pt_at_end) begin
                    state_nxt = last_leaf ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (!pipe_inner_valid) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        job_done  = (state == S_DONE);
        mem_csb   = !issue;
        dbg_state = state;
    end

    assign mem_leaf_addr = leaf_reg;
    assign mem_pt_addr   = pt_cnt;

    // -------------------------------------------------------------------------
    // Leaf / point counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leaves_left <= 4'd0;
            leaf_reg    <= 6'd0;
            pt_cnt      <= 9'd0;
            first_leaf  <= 1'b0;
        end else begin
            if (job_acc) begin
                leaves_left <= job_num_leaves;
                first_leaf  <= 1'b1;
            end
            if (leaf_acc) begin
                leaf_reg <= leaf_idx;
                pt_cnt   <= 9'd0;
            end
            if (issue) begin
                // pt_cnt parks on the last point and is cleared by the next
                // leaf acceptance, so it never wraps.
                if (pt_at_end) begin
                    leaves_left <= leaves_left - 4'd1;
                    first_leaf  <= 1'b0;
                end else begin
                    pt_cnt <= pt_cnt + 9'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read-tag pipe, which advances every cycle regardless of pause
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pv[i]    <= 1'b0;
                pf[i]    <= 1'b0;
                pl[i]    <= 1'b0;
                pleaf[i] <= 6'd0;
            end
        end else begin
            pv[0]    <= issue;
            pf[0]    <= issue && first_leaf && (pt_cnt == 9'd0);
            pl[0]    <= issue && last_leaf && pt_at_end;
            pleaf[0] <= leaf_reg;
            for (int i = 1; i < READ_LAT; i++) begin
                pv[i]    <= pv[i-1];
                pf[i]    <= pf[i-1];
                pl[i]    <= pl[i-1];
                pleaf[i] <= pleaf[i-1];
            end
        end
    end

    always_comb begin
        dp_valid      = pv[READ_LAT-1];
        dp_restart    = pf[READ_LAT-1];
        dp_query_last = pl[READ_LAT-1];
        dp_leaf_idx   = pleaf[READ_LAT-1];
    end

`ifdef LEAF_SCAN_PERF_EN
    // -------------------------------------------------------------------------
    // Activity counters, cleared per job and saturating
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cycles  <= 32'd0;
            perf_pause_cycles <= 32'd0;
        end else if (job_acc) begin
            perf_busy_cycles  <= 32'd0;
            perf_pause_cycles <= 32'd0;
        end else begin
            if (busy && (perf_busy_cycles != 32'hFFFF_FFFF)) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (((state == S_SCAN) || (state == S_FETCH)) && pause &&
                (perf_pause_cycles != 32'hFFFF_FFFF)) begin
                perf_pause_cycles <= perf_pause_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/leaf_scan_sched.md
# leaf_scan_sched

Sequences leaf-point scans into the 8-wide running-minimum stage of the ANN search datapath. Each job runs one batch of 8 queries against a list of candidate leaves: the block accepts the list one leaf index at a time and steps the point address through every point of each leaf. It issues the leaf-memory reads and generates the aligned `valid_in` / `restart` / `query_last_in` / `leaf_idx_in` strobes the min stage consumes. It also reports job completion to the top-level search FSM.

## Interface
- `LEAF_SIZE`, 8: points per leaf; 2..512.
- `READ_LAT`, 1: leaf-memory read latency in cycles; 1..4.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `job_valid` in 1: job offer.
- `job_ready` out 1: high only in IDLE.
- `job_num_leaves` in 4: leaves in the job, 0..15.
- `leaf_valid` in 1: candidate leaf offer.
- `leaf_ready` out 1: high when in FETCH and `pause` is low.
- `leaf_idx` in 6: candidate leaf index.
- `pause` in 1: downstream back-pressure; blocks new reads and new leaf acceptance.
- `mem_csb` out 1: leaf-memory chip select, active-low.
- `mem_leaf_addr` out 6: leaf being read.
- `mem_pt_addr` out 9: point within the leaf.
- `dp_valid` out 1: drives the min stage `valid_in`.
- `dp_restart` out 1: drives the min stage `restart`.
- `dp_query_last` out 1: drives the min stage `query_last_in`.
- `dp_leaf_idx` out 6: drives the min stage `leaf_idx_in`.
- `busy` out 1: high whenever the state is not IDLE.
- `job_done` out 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: wait for a job.
  - FETCH: wait for the next leaf index.
  - SCAN: issue one read per cycle.
  - DRAIN: wait for the read pipe to empty.
  - DONE: one cycle.
- Job handshake: a job is accepted on `job_valid & job_ready`.
  - The leaf count is latched into `leaves_left`; the state goes to FETCH.
  - If `job_num_leaves`=0, the state goes straight to DONE instead; no reads and no `dp_valid` occur.
- FETCH: on `leaf_valid & leaf_ready`, latch `leaf_idx`, clear `pt_cnt`, go to SCAN.
- SCAN: each cycle with `pause`=0:
  - assert `mem_csb`=0, `mem_leaf_addr`=latched leaf, `mem_pt_addr`=`pt_cnt`;
  - increment `pt_cnt`.
- SCAN with `pause`=1: `mem_csb`=1 and `pt_cnt` holds.
- After the read with `pt_cnt`=LEAF_SIZE-1:
  - decrement `leaves_left`;
  - go to FETCH if leaves remain, otherwise go to DRAIN.
- Read-tag pipe: a READ_LAT-deep shift register of {valid, first, last, leaf}, tagged at issue time.
  - first = (first leaf of the job) & (`pt_cnt`=0).
  - last = (`leaves_left`=1) & (`pt_cnt`=LEAF_SIZE-1).
  - The pipe advances every cycle regardless of `pause`.
  - `dp_*` are driven from the pipe's final stage.
- DRAIN: leave when the pipe holds no valid entries; go to DONE.
- DONE: `job_done`=1 for one cycle, then IDLE.
- Reset: all state, counters and the pipe are cleared asynchronously; in-flight reads are dropped.
- Reset values: every output is 0 except `mem_csb`=1 and `job_ready`=1.

## Timing
- A job accepted in cycle T gives FETCH at T+1.
- A leaf accepted in cycle L gives reads at L+1 .. L+LEAF_SIZE.
- A read issued in cycle t gives `dp_valid` at t+READ_LAT, with `dp_leaf_idx` / `dp_restart` / `dp_query_last` aligned to it.
- There is one bubble cycle per leaf boundary (FETCH). Minimum job length is N·(LEAF_SIZE+1)+READ_LAT+2 cycles from acceptance to `job_done`.
- `job_done` is asserted one cycle after `dp_query_last`, coincident with the min stage's `query_last_out`.
- `pause` takes effect the same cycle it is high; issue resumes the cycle after it falls.
- `pt_cnt` is 9 bits and never wraps: the limit is compared exactly at LEAF_SIZE-1.

## Configuration
- `LEAF_SCAN_PERF_EN` defined:
  - Adds outputs `perf_busy_cycles` (32) and `perf_pause_cycles` (32).
  - Both are cleared on reset and on job acceptance; both saturate at all-ones.
  - `perf_busy_cycles` counts cycles with `busy`=1.
  - `perf_pause_cycles` counts cycles in SCAN or FETCH with `pause`=1.
- `LEAF_SCAN_PERF_EN` undefined: neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- READ_LAT=1, LEAF_SIZE=8, job of 2 leaves {5, 9} with `leaf_valid` held high:
  - 16 `dp_valid` pulses, addresses 0..7 twice;
  - `dp_restart` only on leaf 5 point 0;
  - `dp_query_last` only on leaf 9 point 7;
  - `job_done` one cycle later.
- Job with `job_num_leaves`=0 -> no `mem_csb` activity; `job_done` is pulsed 2 cycles after acceptance.
- `pause` held high for 3 cycles mid-leaf at `pt_cnt`=4 -> reads stop for 3 cycles; the `dp_valid` stream resumes at point 4 with no duplicated or skipped points.
- READ_LAT=3, single leaf 63 -> each `dp_valid` lags its `mem_csb`=0 cycle by exactly 3; DRAIN lasts until the last tag exits.
- `rst_n` asserted during SCAN of leaf 2 of 3 -> next cycle: `busy`=0, `dp_valid`=0, `mem_csb`=1, `job_ready`=1; a new job runs cleanly with `dp_restart` on its first point.
- `leaf_valid` withheld for 5 cycles between leaves -> FETCH holds, `mem_csb`=1; with `LEAF_SCAN_PERF_EN`, `perf_busy_cycles` includes those 5 cycles.
